// File: rtl/branch_pkg.sv
// Shared definitions for the pipelined branch unit.
//   - 9-bit opcode encodings of the decoded branch family
//   - branch_stage_t: one pipeline slot {valid, taken, wr, addr, link, target}
//   - sext_shl2: sign-extend a 16-bit word offset and convert it to bytes
// Field numbering in the architecture is MSB-first (bit 0 = MSB). Here the
// usual descending ranges are used, so architectural bit 0 maps to the top
// bit of each field.
package branch_pkg;

  localparam logic [8:0] OP_BR    = 9'b001100100;
  localparam logic [8:0] OP_BRA   = 9'b001100000;
  localparam logic [8:0] OP_BRSL  = 9'b001100110;
  localparam logic [8:0] OP_BRASL = 9'b001100010;
  localparam logic [8:0] OP_BRZ   = 9'b001000000;
  localparam logic [8:0] OP_BRNZ  = 9'b001000010;
  localparam logic [8:0] OP_BRHZ  = 9'b001000100;
  localparam logic [8:0] OP_BRHNZ = 9'b001000110;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] link;
    logic [31:0] target;
  } branch_stage_t;

  // Word offset -> signed byte offset, 32 bits wide.
  function automatic logic [31:0] sext_shl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_stage_reg.sv
// One slot of the branch pipeline.
//   clk, reset : clock, asynchronous active-high reset (clears whole slot)
//   stall      : hold the slot contents
//   kill       : clear valid on the next edge; wins over stall
//   d / q      : incoming / registered slot
// The payload is only overwritten when a valid entry arrives, so the final
// slot keeps presenting the last real branch while bubbles pass through.
module branch_stage_reg
  import branch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          kill,
  input  branch_stage_t d,
  output branch_stage_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (kill)
      q.valid <= 1'b0;
    else if (!stall) begin
      if (d.valid)
        q <= d;
      else
        q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_unit_pipe.sv
// Pipelined branch unit: decode/resolve at issue, then LATENCY register slots.
// Parameters: LATENCY (slots, >=1), LS_ADDR_BITS (target/link mask width),
//             RT_WIDTH (register width, >=33).
// Inputs : clk, reset (async, high), valid_in, opcode9, immediate16, addr_rt,
//          rt (condition word is the top 32 bits), PCin, stall, flush.
// Outputs: pipe_data (link in top word, rest zero), pipe_addr, pipe_wr,
//          redirect (taken branch leaving the last slot), PCout (its target).
module branch_unit_pipe
  import branch_pkg::*;
#(
  parameter int LATENCY      = 4,
  parameter int LS_ADDR_BITS = 18,
  parameter int RT_WIDTH     = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [8:0]          opcode9,
  input  logic [15:0]         immediate16,
  input  logic [6:0]          addr_rt,
  input  logic [RT_WIDTH-1:0] rt,
  input  logic [31:0]         PCin,
  input  logic                stall,
  input  logic                flush,
  output logic [RT_WIDTH-1:0] pipe_data,
  output logic [6:0]          pipe_addr,
  output logic                pipe_wr,
  output logic                redirect,
  output logic [31:0]         PCout
);

  localparam logic [31:0] LS_MASK = (LS_ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                  : 32'((64'd1 << LS_ADDR_BITS) - 64'd1);

  // ---------------- decode / resolve ----------------
  logic [31:0]   rt_word;
  logic [15:0]   rt_half;
  logic [31:0]   rel_tgt, abs_tgt;
  branch_stage_t issue;
  logic          unused_rt;

  assign rt_word   = rt[RT_WIDTH-1 -: 32];
  assign rt_half   = rt_word[15:0];
  assign unused_rt = ^rt[RT_WIDTH-33:0];
  assign rel_tgt   = (PCin + sext_shl2(immediate16)) & LS_MASK;
  assign abs_tgt   = sext_shl2(immediate16) & LS_MASK;

  always_comb begin
    issue        = '0;
    issue.valid  = valid_in;
    issue.addr   = addr_rt;
    issue.link   = (PCin + 32'd4) & LS_MASK;
    issue.target = rel_tgt;
    case (opcode9)
      OP_BR:    issue.taken = 1'b1;
      OP_BRA:   begin issue.taken = 1'b1; issue.target = abs_tgt; end
      OP_BRSL:  begin issue.taken = 1'b1; issue.wr = 1'b1; end
      OP_BRASL: begin issue.taken = 1'b1; issue.wr = 1'b1; issue.target = abs_tgt; end
      OP_BRZ:   issue.taken = (rt_word == 32'd0);
      OP_BRNZ:  issue.taken = (rt_word != 32'd0);
      OP_BRHZ:  issue.taken = (rt_half == 16'd0);
      OP_BRHNZ: issue.taken = (rt_half != 16'd0);
      default:  ;  // unknown opcode travels as a harmless bubble
    endcase
  end

  // ---------------- pipeline ----------------
  branch_stage_t stg     [LATENCY];
  branch_stage_t stage_d [LATENCY];
  branch_stage_t last;
  logic          squash, kill;

  assign last = stg[LATENCY-1];
  // A redirect only squashes once it actually leaves (stall released), and
  // the squash also covers the slot moving into the last position and the
  // branch issuing this cycle -- hence one kill for every slot.
  assign squash = last.valid & last.taken & ~stall;
  assign kill   = flush | squash;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = issue;
    end else begin : g_body
      assign stage_d[i] = stg[i-1];
    end
    branch_stage_reg u_reg (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .kill  (kill),
      .d     (stage_d[i]),
      .q     (stg[i])
    );
  end

  // ---------------- outputs ----------------
  assign redirect  = last.valid & last.taken;
  assign pipe_wr   = last.valid & last.wr;
  assign PCout     = last.target;
  assign pipe_addr = last.addr;

  always_comb begin
    pipe_data                   = '0;
    pipe_data[RT_WIDTH-1 -: 32] = last.link;
  end

endmodule

// File: doc/branch_unit_pipe.md
# branch_unit_pipe

Parametrised successor to the single-stage branch unit of the Cell-CPU-Lite odd pipe. Each issued branch is decoded and resolved in the first stage, then carried through a configurable-depth pipeline. The unit produces a PC redirect, an optional link write-back for the register file, and squashes younger in-flight branches when a redirect fires. It also adds issue-valid, stall and external-flush handling that the single-stage unit lacks.

## Interface
Parameters:
- LATENCY, 4, pipeline depth in cycles from issue to result (≥1)
- LS_ADDR_BITS, 18, local-store address width; all targets masked to this width
- RT_WIDTH, 128, register width

Ports (bit 0 = MSB throughout):
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- valid_in  in  1  branch issued this cycle
- opcode9  in  9  branch opcode
- immediate16  in  16  signed word offset (I16)
- addr_rt  in  7  target/link register address
- rt  in  RT_WIDTH  register value used for the condition test
- PCin  in  32  byte address of the issued branch
- stall  in  1  hold all stages
- flush  in  1  external kill of all in-flight stages
- pipe_data  out  RT_WIDTH  link value (word 0 = PC+4, words 1–3 = 0)
- pipe_addr  out  7  write-back register address
- pipe_wr  out  1  write-back enable
- redirect  out  1  taken branch resolved, one-cycle pulse
- PCout  out  32  redirect target, valid only when redirect=1

## Operation
- Decoded opcodes:
  - br 001100100: always taken, relative.
  - bra 001100000: always taken, absolute.
  - brsl 001100110: relative, writes link.
  - brasl 001100010: absolute, writes link.
  - brz 001000000 / brnz 001000010: test rt[0:31].
  - brhz 001000100 / brhnz 001000110: test rt[16:31].
  - Any other opcode: valid with taken=0 and wr=0, i.e. a bubble.
- Target calculation:
  - Relative: (PCin + sext(immediate16)<<2) masked to LS_ADDR_BITS, upper bits zero.
  - Absolute: (sext(immediate16)<<2) masked the same way.
  - Wrap-around is modulo 2^LS_ADDR_BITS.
- Link: (PCin+4) masked to LS_ADDR_BITS. pipe_wr=1 only for brsl/brasl, independent of the taken condition.
- Stage 0 registers {valid, taken, wr, addr, link, target} on a clk edge when valid_in=1 and stall=0. Stages 1..LATENCY-1 shift when stall=0.
- Outputs come from the last stage:
  - redirect = valid & taken.
  - pipe_wr = valid & wr.
  - PCout and pipe_data hold their last value when not valid.
- Self-squash: the cycle the last stage asserts redirect, the next edge clears valid in all younger stages. An instruction issued in that same cycle is also dropped.
- flush=1 clears every stage valid on the next edge, including the issuing input. flush has priority over stall. Flush does not cancel the current cycle's outputs.
- stall=1 holds the contents of all stages and drops valid_in. Outputs stay constant, so redirect and pipe_wr remain asserted for as long as stall holds them.

## Timing
- Latency: issue at edge N gives outputs valid after edge N+LATENCY-1, i.e. in cycle LATENCY counted from the issue edge.
- Throughput: one branch per cycle.
- Reset values (asynchronous): all valids 0, redirect=0, pipe_wr=0, PCout=0, pipe_data=0, pipe_addr=0.
- Reset mid-operation discards every in-flight branch. The first issue after reset deasserts is accepted on the first edge.
- Simultaneous events:
  - redirect and flush in the same cycle: both clear younger stages; the redirect pulse is still presented.
  - redirect and stall in the same cycle: the redirect stays asserted until stall drops; the squash happens on that release edge.

## Structure
- The shared package branch_pkg holds:
  - the 9-bit opcode localparams;
  - the branch_stage_t struct {valid, taken, wr, addr[0:6], link[0:31], target[0:31]};
  - the sext-shift function.
- One sub-module, branch_stage_reg: a single pipeline register with stall, kill and async reset. It is instantiated LATENCY times via generate. Decode lives in the top.

## Test plan
Configuration for all scenarios: LATENCY=4, rt[0:31]=32'h3727C5AC.

- br at PCin=4, imm=1 → 4 cycles later redirect=1, PCout=8, pipe_wr=0.
- brsl at PCin=8, imm=2, addr_rt=1 → redirect=1, PCout=16, pipe_wr=1, pipe_addr=1, pipe_data[0:31]=12.
- brz at PCin=12 → redirect=0 and no write. brnz at PCin=16, imm=4 → PCout=32. A br issued in the cycle after the brnz never produces a redirect.
- brhz with rt[16:31]=16'hC5AC → not taken. Set rt[0:31]=0 and repeat brz → taken.
- Relative br at PCin=32'h3FFFC, imm=1 → PCout=0 (LS wrap). bra with imm=16'hFFFF → PCout=32'h3FFFC.
- Issue 3 branches back-to-back, then:
  - assert stall for 2 cycles → outputs frozen;
  - assert flush → no further redirect;
  - assert reset with stages full → all outputs 0 immediately.
